ntm_xnor_vector_decoder: RTL and testbench
==========================================

Name: ntm_xnor_vector_decoder

Overview:
- Sequential vector-level counterpart of the registered scalar XNOR gate: recovers an operand stream from an XNOR-encoded stream and its key stream (B = ~(KEY ^ CODE); XNOR is self-inverse).
- Consumes SIZE_IN element pairs through per-operand enable handshakes and emits one decoded element per pair, then signals completion.
- Sits in computing/information/logic_gate beside the scalar gates, for use by vector-level NTM datapaths.

Parameters:
DATA_SIZE, 64, element width in bits
CONTROL_SIZE, 64, width of SIZE_IN and the internal element index

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
START  input  1  single-cycle request to begin a vector; sampled only in STARTER_STATE
READY  output  1  one-cycle pulse: vector complete
SIZE_IN  input  CONTROL_SIZE  element count; latched on accepted START
DATA_ENABLE  output  1  high while the block accepts operands
DATA_KEY_IN_ENABLE  input  1  DATA_KEY_IN valid this cycle
DATA_KEY_IN  input  DATA_SIZE  key element
DATA_CODE_IN_ENABLE  input  1  DATA_CODE_IN valid this cycle
DATA_CODE_IN  input  DATA_SIZE  encoded element
DATA_OUT_ENABLE  output  1  one-cycle pulse: DATA_OUT holds a new decoded element
DATA_OUT  output  DATA_SIZE  decoded element, ~(key ^ code)

Behaviour:
- Reset (RST=0, asynchronous, overrides everything): READY=0, DATA_ENABLE=0, DATA_OUT_ENABLE=0, DATA_OUT=0, index=0, size=0, key/code registers=0, key/code captured flags=0, state=STARTER_STATE. Reset mid-vector abandons the vector; no READY is produced.
- FSM states: STARTER_STATE, INPUT_STATE, ENDER_STATE. READY and DATA_OUT_ENABLE default to 0 every cycle unless set below.
- STARTER_STATE:
  - START=1 and SIZE_IN=0: READY=1 next cycle; stay in STARTER_STATE; no output produced.
  - START=1 and SIZE_IN>0: latch size, index=0, clear flags, DATA_ENABLE=1, go to INPUT_STATE.
- INPUT_STATE:
  - DATA_KEY_IN_ENABLE=1: capture key and set key flag. DATA_CODE_IN_ENABLE=1: capture code and set code flag. Both may occur in the same cycle, and either may arrive first.
  - A repeated enable for an already-captured operand overwrites the stored value (last write wins) until the pair completes.
  - Pair completes in the cycle where both operands become available (from flags or from same-cycle enables). On the next edge: DATA_OUT=~(key ^ code) using the values presented that cycle; DATA_OUT_ENABLE=1 for one cycle; both flags clear.
  - Latency: the output pulse appears one cycle after the cycle in which the second operand is sampled.
  - Non-final pair (index < size-1): index increments and the block stays in INPUT_STATE. It can accept a new operand in the cycle immediately after completion, giving full throughput of one element per cycle.
  - Final pair (index = size-1): DATA_ENABLE=0 and go to ENDER_STATE. Enables arriving after the final pair are ignored.
- ENDER_STATE: READY=1 for one cycle, coincident with the final DATA_OUT_ENABLE deassertion (one cycle after the final output pulse); index=0; return to STARTER_STATE.
- START outside STARTER_STATE is ignored. DATA_OUT holds its last value between pulses.
- Width rules: index and size are CONTROL_SIZE bits, and compares are unsigned. The result is exactly DATA_SIZE bits with no extension.

Decomposition:
- Shared package ntm_logic_pkg holds the FSM state enum (STARTER_STATE, INPUT_STATE, ENDER_STATE), ZERO_DATA, ZERO_CONTROL, and ONE_CONTROL.
- No sub-module. The per-element XNOR is a single expression, and instantiating the registered scalar gate would add an unwanted cycle of latency.

Test Plan:
- DATA_SIZE=8, SIZE_IN=1: START, then key 0xF0 and code 0x0F in the same cycle -> next cycle DATA_OUT=0x00 with DATA_OUT_ENABLE=1; the cycle after, READY=1.
- SIZE_IN=3, pairs (0xAA,0xAA), (0x00,0xFF), (0x3C,0xC3) back-to-back every cycle -> outputs 0xFF, 0x00, 0x00 on consecutive cycles; READY once.
- Split arrival: code 0x55 in cycle t, key 0x0F in cycle t+3 -> DATA_OUT=0xA5 at t+4, with no output before.
- Overwrite: key 0x11 then key 0x22 before code 0x22 -> DATA_OUT=0xFF.
- SIZE_IN=0 -> READY pulse one cycle after START, with no DATA_OUT_ENABLE and DATA_ENABLE never high. START while in INPUT_STATE has no effect.
- Assert RST=0 mid-vector (after 1 of 3 elements), release, then START with SIZE_IN=1 and pair (0x0F,0x0F) -> all outputs 0 during reset, one output of 0xFF, then READY; no stale flags carry over.

Source files
------------

// File: rtl/ntm_logic_pkg.sv
// Shared definitions for the NTM logic-gate blocks: FSM state encoding and
// common zero/one constants, sized at the widest parameter default.
package ntm_logic_pkg;

    localparam int unsigned NTM_CONST_WIDTH = 64;

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        INPUT_STATE   = 2'd1,
        ENDER_STATE   = 2'd2
    } ntm_state_t;

    localparam logic [NTM_CONST_WIDTH-1:0] ZERO_DATA    = '0;
    localparam logic [NTM_CONST_WIDTH-1:0] ZERO_CONTROL = '0;
    localparam logic [NTM_CONST_WIDTH-1:0] ONE_CONTROL  = NTM_CONST_WIDTH'(1);

endpackage

// File: rtl/ntm_xnor_vector_decoder.sv
// Vector XNOR decoder: pairs key/code elements arriving on independent enables
// and emits ~(key ^ code) per pair, pulsing READY once the vector is consumed.
module ntm_xnor_vector_decoder
    import ntm_logic_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,

    output logic                    DATA_ENABLE,
    input  logic                    DATA_KEY_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_KEY_IN,
    input  logic                    DATA_CODE_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_CODE_IN,

    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    localparam logic [DATA_SIZE-1:0]    ZERO_D = DATA_SIZE'(ZERO_DATA);
    localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(ONE_CONTROL);

    ntm_state_t              state_q, state_d;
    logic [CONTROL_SIZE-1:0] index_q, index_d;
    logic [CONTROL_SIZE-1:0] size_q, size_d;
    logic [DATA_SIZE-1:0]    key_q, key_d;
    logic [DATA_SIZE-1:0]    code_q, code_d;
    logic                    key_flag_q, key_flag_d;
    logic                    code_flag_q, code_flag_d;
    logic                    ready_q, ready_d;
    logic                    data_enable_q, data_enable_d;
    logic                    data_out_enable_q, data_out_enable_d;
    logic [DATA_SIZE-1:0]    data_out_q, data_out_d;

    // Operand view for this cycle: a same-cycle enable takes precedence over the stored copy
    logic                    key_avail_c;
    logic                    code_avail_c;
    logic [DATA_SIZE-1:0]    key_val_c;
    logic [DATA_SIZE-1:0]    code_val_c;
    logic                    last_pair_c;

    assign key_avail_c  = key_flag_q  | DATA_KEY_IN_ENABLE;
    assign code_avail_c = code_flag_q | DATA_CODE_IN_ENABLE;
    assign key_val_c    = DATA_KEY_IN_ENABLE  ? DATA_KEY_IN  : key_q;
    assign code_val_c   = DATA_CODE_IN_ENABLE ? DATA_CODE_IN : code_q;
    assign last_pair_c  = (index_q == (size_q - ONE_C));

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q           <= STARTER_STATE;
            index_q           <= ZERO_C;
            size_q            <= ZERO_C;
            key_q             <= ZERO_D;
            code_q            <= ZERO_D;
            key_flag_q        <= 1'b0;
            code_flag_q       <= 1'b0;
            ready_q           <= 1'b0;
            data_enable_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
            data_out_q        <= ZERO_D;
        end else begin
            state_q           <= state_d;
            index_q           <= index_d;
            size_q            <= size_d;
            key_q             <= key_d;
            code_q            <= code_d;
            key_flag_q        <= key_flag_d;
            code_flag_q       <= code_flag_d;
            ready_q           <= ready_d;
            data_enable_q     <= data_enable_d;
            data_out_enable_q <= data_out_enable_d;
            data_out_q        <= data_out_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d           = state_q;
        index_d           = index_q;
        size_d            = size_q;
        key_d             = key_q;
        code_d            = code_q;
        key_flag_d        = key_flag_q;
        code_flag_d       = code_flag_q;
        ready_d           = 1'b0;
        data_enable_d     = data_enable_q;
        data_out_enable_d = 1'b0;
        data_out_d        = data_out_q;

        case (state_q)
            STARTER_STATE: begin
                if (START) begin
                    if (SIZE_IN == ZERO_C) begin
                        ready_d = 1'b1;
                    end else begin
                        size_d        = SIZE_IN;
                        index_d       = ZERO_C;
                        key_flag_d    = 1'b0;
                        code_flag_d   = 1'b0;
                        data_enable_d = 1'b1;
                        state_d       = INPUT_STATE;
                    end
                end
            end

            INPUT_STATE: begin
                if (DATA_KEY_IN_ENABLE) begin
                    key_d      = DATA_KEY_IN;
                    key_flag_d = 1'b1;
                end
                if (DATA_CODE_IN_ENABLE) begin
                    code_d      = DATA_CODE_IN;
                    code_flag_d = 1'b1;
                end
                if (key_avail_c && code_avail_c) begin
                    data_out_d        = ~(key_val_c ^ code_val_c);
                    data_out_enable_d = 1'b1;
                    key_flag_d        = 1'b0;
                    code_flag_d       = 1'b0;
                    if (last_pair_c) begin
                        data_enable_d = 1'b0;
                        state_d       = ENDER_STATE;
                    end else begin
                        index_d = index_q + ONE_C;
                    end
                end
            end

            ENDER_STATE: begin
                ready_d = 1'b1;
                index_d = ZERO_C;
                state_d = STARTER_STATE;
            end

            default: begin
                state_d = STARTER_STATE;
            end
        endcase
    end

    assign READY           = ready_q;
    assign DATA_ENABLE     = data_enable_q;
    assign DATA_OUT_ENABLE = data_out_enable_q;
    assign DATA_OUT        = data_out_q;

endmodule

// File: tb/tb_ntm_xnor_vector_decoder.sv
// Directed self-checking bench for ntm_xnor_vector_decoder (8-bit elements).
module tb_ntm_xnor_vector_decoder;

    localparam int unsigned DATA_SIZE    = 8;
    localparam int unsigned CONTROL_SIZE = 16;

    logic                    CLK;
    logic                    RST;
    logic                    START;
    logic                    READY;
    logic [CONTROL_SIZE-1:0] SIZE_IN;
    logic                    DATA_ENABLE;
    logic                    DATA_KEY_IN_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_KEY_IN;
    logic                    DATA_CODE_IN_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_CODE_IN;
    logic                    DATA_OUT_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_OUT;

    int checks;
    int errors;

    ntm_xnor_vector_decoder #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .START               (START),
        .READY               (READY),
        .SIZE_IN             (SIZE_IN),
        .DATA_ENABLE         (DATA_ENABLE),
        .DATA_KEY_IN_ENABLE  (DATA_KEY_IN_ENABLE),
        .DATA_KEY_IN         (DATA_KEY_IN),
        .DATA_CODE_IN_ENABLE (DATA_CODE_IN_ENABLE),
        .DATA_CODE_IN        (DATA_CODE_IN),
        .DATA_OUT_ENABLE     (DATA_OUT_ENABLE),
        .DATA_OUT            (DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ke, input logic [7:0] k, input logic ce, input logic [7:0] c);
        DATA_KEY_IN_ENABLE  = ke;
        DATA_KEY_IN         = k;
        DATA_CODE_IN_ENABLE = ce;
        DATA_CODE_IN        = c;
    endtask

    task automatic start_vec(input int n);
        START   = 1'b1;
        SIZE_IN = CONTROL_SIZE'(n);
        tick();
        START   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [7:0] val);
        check({tag, "_doe"}, 64'(DATA_OUT_ENABLE), 64'(en));
        check({tag, "_out"}, 64'(DATA_OUT), 64'(val));
    endtask

    initial begin
        logic [7:0] keys [3];
        logic [7:0] codes[3];
        logic [7:0] exps [3];
        checks = 0;
        errors = 0;
        RST = 1'b0;
        START = 1'b0;
        SIZE_IN = '0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);

        // Reset state
        tick();
        check("rst_ready", 64'(READY), 64'd0);
        check("rst_de", 64'(DATA_ENABLE), 64'd0);
        expect_out("rst", 1'b0, 8'h00);
        RST = 1'b1;
        tick();

        // Single element, both operands same cycle
        start_vec(1);
        check("t1_de", 64'(DATA_ENABLE), 64'd1);
        drive(1'b1, 8'hF0, 1'b1, 8'h0F);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        expect_out("t1", 1'b1, 8'h00);
        check("t1_de_off", 64'(DATA_ENABLE), 64'd0);
        check("t1_ready_early", 64'(READY), 64'd0);
        tick();
        check("t1_ready", 64'(READY), 64'd1);
        check("t1_doe_off", 64'(DATA_OUT_ENABLE), 64'd0);
        tick();
        check("t1_ready_once", 64'(READY), 64'd0);

        // Three elements back-to-back
        keys  = '{8'hAA, 8'h00, 8'h3C};
        codes = '{8'hAA, 8'hFF, 8'hC3};
        exps  = '{8'hFF, 8'h00, 8'h00};
        start_vec(3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, keys[i], 1'b1, codes[i]);
            tick();
            expect_out($sformatf("t2_e%0d", i), 1'b1, exps[i]);
            check($sformatf("t2_nrdy%0d", i), 64'(READY), 64'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        check("t2_ready", 64'(READY), 64'd1);
        tick();
        check("t2_ready_once", 64'(READY), 64'd0);

        // Split arrival then overwrite within one vector of two
        start_vec(2);
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        check("t3_wait0", 64'(DATA_OUT_ENABLE), 64'd0);
        tick();
        check("t3_wait1", 64'(DATA_OUT_ENABLE), 64'd0);
        tick();
        check("t3_wait2", 64'(DATA_OUT_ENABLE), 64'd0);
        drive(1'b1, 8'h0F, 1'b0, 8'h00);
        tick();
        expect_out("t3", 1'b1, 8'hA5);
        drive(1'b1, 8'h11, 1'b0, 8'h00);
        tick();
        check("t4_wait0", 64'(DATA_OUT_ENABLE), 64'd0);
        check("t4_hold", 64'(DATA_OUT), 64'hA5);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        tick();
        check("t4_wait1", 64'(DATA_OUT_ENABLE), 64'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h22);
        tick();
        expect_out("t4", 1'b1, 8'hFF);
        // Enables after the final pair must be ignored
        drive(1'b1, 8'h00, 1'b1, 8'h00);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        check("t4_ready", 64'(READY), 64'd1);
        expect_out("t4_ign", 1'b0, 8'hFF);
        tick();

        // Zero-length vector
        start_vec(0);
        check("t5_ready", 64'(READY), 64'd1);
        check("t5_de", 64'(DATA_ENABLE), 64'd0);
        check("t5_doe", 64'(DATA_OUT_ENABLE), 64'd0);
        tick();
        check("t5_ready_once", 64'(READY), 64'd0);
        check("t5_de_after", 64'(DATA_ENABLE), 64'd0);

        // START while in INPUT_STATE must not relatch the size
        start_vec(2);
        START = 1'b1;
        SIZE_IN = CONTROL_SIZE'(5);
        drive(1'b1, 8'h01, 1'b1, 8'h01);
        tick();
        START = 1'b0;
        expect_out("t6_e0", 1'b1, 8'hFF);
        drive(1'b1, 8'hF0, 1'b1, 8'hFF);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        expect_out("t6_e1", 1'b1, 8'hF0);
        tick();
        check("t6_ready", 64'(READY), 64'd1);
        tick();

        // Reset mid-vector, then a clean single-element vector
        start_vec(3);
        drive(1'b1, 8'h12, 1'b1, 8'h34);
        tick();
        expect_out("t7_pre", 1'b1, 8'hD9);
        drive(1'b1, 8'h77, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        #2;
        RST = 1'b0;
        #1;
        check("t7_rst_de", 64'(DATA_ENABLE), 64'd0);
        check("t7_rst_ready", 64'(READY), 64'd0);
        expect_out("t7_rst", 1'b0, 8'h00);
        tick();
        expect_out("t7_rst_hold", 1'b0, 8'h00);
        RST = 1'b1;
        tick();
        check("t7_no_ready", 64'(READY), 64'd0);
        start_vec(1);
        drive(1'b0, 8'h00, 1'b1, 8'h0F);
        tick();
        check("t7_no_stale", 64'(DATA_OUT_ENABLE), 64'd0);
        drive(1'b1, 8'h0F, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        expect_out("t7", 1'b1, 8'hFF);
        tick();
        check("t7_ready", 64'(READY), 64'd1);
        tick();
        check("t7_ready_once", 64'(READY), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
